// File: rtl/arb_pkg.sv
// Shared state encoding and counter width for the shared-resource arbiter.
package arb_pkg;

    localparam int unsigned HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after last_owner+1, wrapping mod N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_owner,
    output logic [IW-1:0] owner,
    output logic          any
);

    logic [IW-1:0] idx;

    // Scan farthest-first so the nearest candidate after last_owner is the final write
    always_comb begin
        owner = '0;
        idx   = '0;
        any   = |req;
        for (int i = int'(N); i >= 1; i--) begin
            idx = IW'((32'(last_owner) + 32'(i)) % N);
            if (req[idx]) begin
                owner = idx;
            end
        end
    end

endmodule

// File: rtl/res_arbiter.sv
// Round-robin arbiter granting N requesters bounded bursts of access to one shared
// valid/ready resource, returning registered results tagged with the owner.
module res_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 8,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] din,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   res_x,
    output logic           res_valid,
    input  logic           res_ready,
    input  logic [W-1:0]   res_y,
    output logic [W-1:0]   dout,
    output logic [N-1:0]   dout_valid
);

    localparam int unsigned IW = $clog2(N);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     last_owner_q, last_owner_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [N-1:0]      dout_valid_q, dout_valid_d;
    logic [W-1:0]      dout_q, dout_d;
    logic [IW-1:0]     pick;
    logic              pick_any;
    logic              owner_req;
    logic              xfer;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .owner      (pick),
        .any        (pick_any)
    );

    // Owner's request and data routed straight to the resource port
    always_comb begin
        owner_req = 1'b0;
        res_x     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (owner_q == IW'(k)) begin
                owner_req = req[k];
                res_x     = din[k*W +: W];
            end
        end
    end

    assign res_valid = (state_q == BUSY) && owner_req;
    assign xfer      = res_valid && res_ready;
    assign hold_inc  = hold_cnt_q + HOLD_W'(1);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        gnt_d        = gnt_q;
        dout_d       = dout_q;
        dout_valid_d = '0;

        if (xfer) begin
            hold_cnt_d   = hold_inc;
            dout_d       = res_y;
            dout_valid_d = N'(1) << owner_q;
        end

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = BUSY;
                    owner_d    = pick;
                    hold_cnt_d = '0;
                    gnt_d      = N'(1) << pick;
                end
            end
            BUSY: begin
                // A final transfer at the hold limit still completes this cycle
                if (!owner_req || (xfer && (hold_inc == HOLD_W'(MAX_HOLD)))) begin
                    state_d = GAP;
                    gnt_d   = '0;
                end
            end
            GAP: begin
                state_d      = IDLE;
                last_owner_d = owner_q;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= IW'(N - 1);
            hold_cnt_q   <= '0;
            gnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            gnt_q        <= gnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign gnt        = gnt_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_res_arbiter.sv
// Directed bench for res_arbiter: rotation, hold limit, ready stalls, early drop and reset abort.
module tb_res_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req, req1;
    logic [N*W-1:0] din;
    logic [N-1:0]   gnt, gnt1, dv, dv1;
    logic [W-1:0]   res_x, res_x1, res_y, res_y1, dout, dout1;
    logic           res_valid, res_valid1, res_ready, res_ready1;
    logic [W-1:0]   prev;
    int             n_vec  = 0;
    int             n_miss = 0;

    res_arbiter #(.N(N), .W(W), .MAX_HOLD(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din        (din),
        .gnt        (gnt),
        .res_x      (res_x),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_y      (res_y),
        .dout       (dout),
        .dout_valid (dv)
    );

    res_arbiter #(.N(N), .W(W), .MAX_HOLD(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req1),
        .din        (din),
        .gnt        (gnt1),
        .res_x      (res_x1),
        .res_valid  (res_valid1),
        .res_ready  (res_ready1),
        .res_y      (res_y1),
        .dout       (dout1),
        .dout_valid (dv1)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        oh    = '0;
        oh[i] = 1'b1;
    endfunction

    function automatic logic [W-1:0] dslice(input int k);
        dslice = 8'(17 * (k + 1));
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req        = '0;
        req1       = '0;
        res_ready  = 1'b1;
        res_ready1 = 1'b1;
        res_y      = '0;
        rst_n      = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rv", 32'(res_valid), 0);
        chk("rst_dv", 32'(dv), 0);
        chk("rst_dout", 32'(dout), 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Entered at the negedge where the first BUSY cycle of 'own' is visible; ready held high
    task automatic burst(input int own, input int nx, input string tag);
        logic [W-1:0] ry;
        for (int j = 0; j < nx; j++) begin
            chk({tag, "_gnt"}, 32'(gnt), 32'(oh(own)));
            chk({tag, "_rv"}, 32'(res_valid), 1);
            chk({tag, "_rx"}, 32'(res_x), 32'(dslice(own)));
            ry    = 8'(j * 5 + own * 48 + 1);
            res_y = ry;
            tick();
            chk({tag, "_dout"}, 32'(dout), 32'(ry));
            chk({tag, "_dv"}, 32'(dv), 32'(oh(own)));
        end
    endtask

    task automatic gap_idle(input string tag);
        chk({tag, "_gap_gnt"}, 32'(gnt), 0);
        chk({tag, "_gap_rv"}, 32'(res_valid), 0);
        tick();
        chk({tag, "_idle_gnt"}, 32'(gnt), 0);
        chk({tag, "_idle_dv"}, 32'(dv), 0);
        tick();
    endtask

    logic [N-1:0] exp_g1 [7];
    logic [N-1:0] exp_d1 [7];

    initial begin
        din        = 32'h4433_2211;
        res_y1     = 8'h5A;
        rst_n      = 1'b1;
        req        = '0;
        req1       = '0;
        res_ready  = 1'b1;
        res_ready1 = 1'b1;
        res_y      = '0;
        tick();

        // Two requesters alternate full bursts
        do_reset();
        req = 4'b0101;
        tick();
        burst(0, 8, "s1a");
        gap_idle("s1a");
        burst(2, 8, "s1b");
        gap_idle("s1b");
        chk("s1_wrap_gnt", 32'(gnt), 32'(4'b0001));

        // All requesting: index-order rotation; reset must restore last_owner=N-1
        do_reset();
        req = 4'b1111;
        tick();
        for (int o = 0; o < 4; o++) begin
            burst(o, 8, $sformatf("s2o%0d", o));
            gap_idle($sformatf("s2o%0d", o));
        end
        chk("s2_wrap_gnt", 32'(gnt), 32'(4'b0001));

        // Ready toggling; then owner drops req while ready is high
        do_reset();
        req  = 4'b0001;
        prev = '0;
        tick();
        for (int j = 0; j < 6; j++) begin
            res_ready = (j % 2 == 0);
            res_y     = 8'(8'hA0 + j);
            chk($sformatf("s3_gnt%0d", j), 32'(gnt), 32'(4'b0001));
            chk($sformatf("s3_rv%0d", j), 32'(res_valid), 1);
            tick();
            if (j % 2 == 0) begin
                prev = 8'(8'hA0 + j);
                chk($sformatf("s3_dout%0d", j), 32'(dout), 32'(prev));
                chk($sformatf("s3_dv%0d", j), 32'(dv), 32'(4'b0001));
            end else begin
                chk($sformatf("s3_dout%0d", j), 32'(dout), 32'(prev));
                chk($sformatf("s3_dv%0d", j), 32'(dv), 0);
            end
        end
        req       = 4'b0000;
        res_ready = 1'b1;
        res_y     = 8'hEE;
        #1;
        chk("s3_drop_rv", 32'(res_valid), 0);
        tick();
        chk("s3_drop_gnt", 32'(gnt), 0);
        chk("s3_drop_dv", 32'(dv), 0);
        chk("s3_drop_dout", 32'(dout), 32'(prev));

        // Owner 2 drops after 3 transfers, late arrivals ignored, next is requester 3
        do_reset();
        req = 4'b0100;
        tick();
        burst(2, 1, "s4a");
        req = 4'b1101;
        burst(2, 2, "s4b");
        req = 4'b1001;
        #1;
        chk("s4_drop_rv", 32'(res_valid), 0);
        tick();
        chk("s4_gap_gnt", 32'(gnt), 0);
        chk("s4_gap_dv", 32'(dv), 0);
        tick();
        chk("s4_idle_gnt", 32'(gnt), 0);
        tick();
        chk("s4_next_gnt", 32'(gnt), 32'(4'b1000));

        // Reset mid-burst right after a transfer edge kills the pending pulse
        do_reset();
        req = 4'b0011;
        tick();
        burst(0, 2, "s5");
        res_y = 8'h77;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("s5_rst_gnt", 32'(gnt), 0);
        chk("s5_rst_rv", 32'(res_valid), 0);
        chk("s5_rst_dv", 32'(dv), 0);
        chk("s5_rst_dout", 32'(dout), 0);
        tick();
        tick();
        chk("s5_rst2_gnt", 32'(gnt), 0);
        chk("s5_rst2_rv", 32'(res_valid), 0);
        chk("s5_rst2_dv", 32'(dv), 0);
        rst_n = 1'b1;
        tick();
        chk("s5_first_gnt", 32'(gnt), 32'(4'b0001));

        // MAX_HOLD=1: single transfers alternating, two idle cycles between
        exp_g1 = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0001};
        exp_d1 = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        do_reset();
        req1 = 4'b0011;
        tick();
        chk("s6_rv", 32'(res_valid1), 1);
        chk("s6_rx", 32'(res_x1), 32'(8'h11));
        for (int c = 0; c < 7; c++) begin
            chk($sformatf("s6_gnt%0d", c), 32'(gnt1), 32'(exp_g1[c]));
            chk($sformatf("s6_dv%0d", c), 32'(dv1), 32'(exp_d1[c]));
            if (c == 1) begin
                chk("s6_dout", 32'(dout1), 32'(8'h5A));
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/res_arbiter.md
RES_ARBITER -- requirements
Module: res_arbiter

Interface
REQ-001 The module SHALL have parameter N, default 4, number of requesters (2..8).
REQ-002 The module SHALL have parameter W, default 8, data width of the shared resource port.
REQ-003 The module SHALL have parameter MAX_HOLD, default 8, maximum transfers per grant (1..255).
REQ-004 The module SHALL have port clk, input, 1, the only clock; all state on rising edge.
REQ-005 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The module SHALL have port req, input, N, per-requester request, level-held.
REQ-007 The module SHALL have port din, input, N*W, requester k data at bits [k*W +: W].
REQ-008 The module SHALL have port gnt, output, N, one-hot-or-zero grant.
REQ-009 The module SHALL have port res_x, output, W, data to the shared resource.
REQ-010 The module SHALL have port res_valid, output, 1, res_x valid.
REQ-011 The module SHALL have port res_ready, input, 1, resource accepts res_x.
REQ-012 The module SHALL have port res_y, input, W, resource result, valid in the same cycle as acceptance.
REQ-013 The module SHALL have port dout, output, W, registered result.
REQ-014 The module SHALL have port dout_valid, output, N, one-cycle pulse marking the owner of dout.

Function
REQ-015 The FSM SHALL have the states IDLE, BUSY and GAP.
REQ-016 In IDLE with any req high, the FSM SHALL pick the owner round-robin, starting at (last_owner+1) mod N, enter BUSY next cycle and assert gnt[owner].
REQ-017 In IDLE with req all zero, the FSM SHALL stay in IDLE with gnt = 0.
REQ-018 In BUSY, res_valid SHALL equal req[owner], and res_x SHALL equal din slice of owner (combinational mux).
REQ-019 A transfer SHALL occur on a cycle with res_valid and res_ready both high.
REQ-020 On each transfer, dout SHALL be loaded with res_y and dout_valid[owner] SHALL pulse on the next cycle (latency 1).
REQ-021 hold_cnt (8 bits) SHALL clear on entry to BUSY and increment per transfer.
REQ-022 BUSY SHALL exit to GAP when req[owner] is low or when a transfer makes hold_cnt equal MAX_HOLD; that transfer SHALL still complete.
REQ-023 GAP SHALL last exactly one cycle with gnt = 0 and res_valid = 0, then go to IDLE; last_owner SHALL be updated to owner.
REQ-024 New requests arriving mid-grant SHALL be ignored until the next IDLE evaluation; no preemption.
REQ-025 If the owner drops req while res_ready is high, no transfer SHALL occur in that cycle.
REQ-026 With a single persistent requester, it SHALL be regranted after GAP (bursts of MAX_HOLD separated by 2 idle cycles: GAP+IDLE).
REQ-027 With N requesters permanently requesting, each SHALL receive exactly MAX_HOLD transfers per rotation, in index order.

Reset
REQ-028 On rst_n low, the FSM SHALL go immediately to IDLE; gnt, res_valid and dout_valid SHALL be 0, dout SHALL be 0, hold_cnt SHALL be 0, and last_owner SHALL be N-1 (so requester 0 wins first).
REQ-029 Reset asserted mid-burst SHALL abort the burst; a pending dout_valid pulse SHALL be suppressed.
REQ-030 Deassertion SHALL be synchronized by the integrator; the block SHALL add no synchronizer.

Structure
REQ-031 State encoding (IDLE=0, BUSY=1, GAP=2) and the hold counter width SHALL live in shared package arb_pkg.
REQ-032 The round-robin picker SHALL be a combinational sub-module rr_pick (inputs req and last_owner, outputs owner index and any).

Verification
REQ-033 Reset, then req=4'b0101 with res_ready=1 held -> gnt=0001 for 8 transfers, GAP, IDLE, then gnt=0100 for 8 transfers, then 0001 again.
REQ-034 req=4'b1111, res_ready=1, MAX_HOLD=8 -> grant order 0,1,2,3,0, with 8 dout_valid pulses per owner.
REQ-035 req0 high with res_ready toggling 1010... -> transfers only on ready cycles; dout = res_y from the accept cycle, one cycle later.
REQ-036 Owner 2 drops req after 3 transfers -> GAP next cycle; hold_cnt at 3; last_owner=2; next grant is the first requester above 2.
REQ-037 rst_n pulsed low during a BUSY transfer -> gnt=0, res_valid=0 and dout_valid=0 immediately and on the following cycle; after release, requester 0 is granted first.
REQ-038 MAX_HOLD=1 with req=4'b0011 -> alternating single transfers, each followed by 2 idle cycles.
